// File: rtl/jtag_host_master.sv
// jtag_host_master: fabric-side JTAG initiator. Runs the TAP through a reset
// walk at start-up, then executes IR scans, DR scans and TAP resets on request,
// returning the TDO bits captured during the shift phase.
module jtag_host_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned MAX_LEN = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_reset_i,
  input  logic                       cmd_ir_i,
  input  logic [$clog2(MAX_LEN)-1:0] cmd_len_i,
  input  logic [MAX_LEN-1:0]         cmd_data_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [MAX_LEN-1:0]         rsp_data_o,
  output logic                       jtag_tck_o,
  output logic                       jtag_tms_o,
  output logic                       jtag_tdi_o,
  input  logic                       jtag_tdo_i
);

  localparam int unsigned LW = $clog2(MAX_LEN);
  // Two spare bits hold L plus the pre/post TMS bits without overflow.
  localparam int unsigned BW = LW + 2;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {INIT, IDLE, SCAN, RESP} state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic               r_armed;
  logic [DW-1:0]      r_div;
  logic               r_high;
  logic [BW-1:0]      r_bit;
  logic [BW-1:0]      r_len;
  logic               r_ir;
  logic               r_rst;
  logic [MAX_LEN-1:0] r_data;
  logic [MAX_LEN-1:0] r_rsp;
  logic               r_tck;
  logic               r_tms;
  logic               r_tdi;

  logic               w_accept;
  logic               w_run;
  logic               w_half_end;
  logic               w_end;
  logic [BW-1:0]      w_start;
  logic [BW-1:0]      w_n;
  logic [BW-1:0]      w_bit_nxt;
  logic               w_cur_shift;
  logic               w_nxt_shift;
  logic [LW-1:0]      w_cur_idx;
  logic [LW-1:0]      w_nxt_idx;
  logic               w_tms_nxt;
  logic               w_tdi_nxt;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, TCK bit bookkeeping and the TMS/TDI values for the next bit.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = (r_state == IDLE) && cmd_valid_i;
    w_run       = (r_state == SCAN) || ((r_state == INIT) && r_armed);
    w_half_end  = w_run && (r_div == DIV_LAST);
    w_start     = r_ir ? BW'(4) : BW'(3);
    w_n         = r_rst ? BW'(6) : (r_len + w_start + BW'(2));
    w_end       = w_half_end && r_high && (r_bit == (w_n - BW'(1)));
    w_bit_nxt   = r_bit + BW'(1);
    w_cur_shift = !r_rst && (r_bit >= w_start) && (r_bit < (w_start + r_len));
    w_nxt_shift = !r_rst && (w_bit_nxt >= w_start) && (w_bit_nxt < (w_start + r_len));
    w_cur_idx   = LW'(r_bit - w_start);
    w_nxt_idx   = LW'(w_bit_nxt - w_start);
    w_tms_nxt   = 1'b0;
    if (r_rst) begin
      w_tms_nxt = (w_bit_nxt < BW'(5));
    end else if (w_bit_nxt < w_start) begin
      w_tms_nxt = r_ir && (w_bit_nxt == BW'(1));
    end else if (w_nxt_shift) begin
      w_tms_nxt = (w_bit_nxt == (w_start + r_len - BW'(1)));
    end else begin
      w_tms_nxt = (w_bit_nxt == (w_start + r_len));
    end
    w_tdi_nxt = w_nxt_shift && r_data[w_nxt_idx];

    case (r_state)
      INIT:    if (w_end) w_state_nxt = IDLE;
      IDLE:    if (cmd_valid_i) w_state_nxt = SCAN;
      SCAN:    if (w_end) w_state_nxt = RESP;
      RESP:    if (rsp_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = INIT;
    endcase

    cmd_ready_o = (r_state == IDLE);
    rsp_valid_o = (r_state == RESP);
  end

  // Command latch, TCK half-period timing, TMS/TDI drive and TDO capture.
  // The start-up walk reuses the reset-command sequence; r_armed makes the
  // first edge after reset release play the role of the accept edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_armed <= 1'b0;
      r_div   <= '0;
      r_high  <= 1'b0;
      r_bit   <= '0;
      r_len   <= '0;
      r_ir    <= 1'b0;
      r_rst   <= 1'b1;
      r_data  <= '0;
      r_rsp   <= '0;
      r_tck   <= 1'b0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
    end else if (w_accept) begin
      r_data <= cmd_data_i;
      r_len  <= BW'(cmd_len_i) + BW'(1);
      r_ir   <= cmd_ir_i;
      r_rst  <= cmd_reset_i;
      r_rsp  <= '0;
      r_bit  <= '0;
      r_div  <= '0;
      r_high <= 1'b0;
      r_tck  <= 1'b0;
      r_tms  <= 1'b1;
      r_tdi  <= 1'b0;
    end else if ((r_state == INIT) && !r_armed) begin
      r_armed <= 1'b1;
    end else if (w_run) begin
      if (w_half_end) begin
        r_div <= '0;
        if (!r_high) begin
          r_tck  <= 1'b1;
          r_high <= 1'b1;
          if (w_cur_shift) begin
            r_rsp[w_cur_idx] <= jtag_tdo_i;
          end
        end else begin
          r_tck  <= 1'b0;
          r_high <= 1'b0;
          if (!w_end) begin
            r_bit <= w_bit_nxt;
            r_tms <= w_tms_nxt;
            r_tdi <= w_tdi_nxt;
          end
        end
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  assign rsp_data_o = r_rsp;
  assign jtag_tck_o = r_tck;
  assign jtag_tms_o = r_tms;
  assign jtag_tdi_o = r_tdi;

endmodule

// File: tb/tb_jtag_host_master.sv
// Bench for jtag_host_master: a behavioural TAP (5-bit IR, IDCODE, 64-bit USER
// register) on the CLK_DIV=4 instance, a pattern-driven TDO on a CLK_DIV=1
// instance, and a scoreboard of expected responses.
module tb_jtag_host_master;

  localparam logic [31:0] IDCODE    = 32'h249511C3;
  localparam logic [63:0] USER_INIT = 64'hDEADBEEF_01234567;
  localparam logic [63:0] PAT_A5    = 64'hA5A5_A5A5_A5A5_A5A5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_reset, cmd_ir, rsp_valid, rsp_ready;
  logic [5:0]  cmd_len;
  logic [63:0] cmd_data, rsp_data;
  logic        tck1, tms1, tdi1, tdo1;

  logic        cmd_valid2, cmd_ready2, cmd_reset2, cmd_ir2, rsp_valid2, rsp_ready2;
  logic [5:0]  cmd_len2;
  logic [63:0] cmd_data2, rsp_data2;
  logic        tck2, tms2, tdi2, tdo2;

  jtag_host_master #(.CLK_DIV(4), .MAX_LEN(64)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_reset_i(cmd_reset),
    .cmd_ir_i(cmd_ir), .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .jtag_tck_o(tck1), .jtag_tms_o(tms1), .jtag_tdi_o(tdi1), .jtag_tdo_i(tdo1)
  );

  jtag_host_master #(.CLK_DIV(1), .MAX_LEN(64)) u_dut_fast (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2), .cmd_reset_i(cmd_reset2),
    .cmd_ir_i(cmd_ir2), .cmd_len_i(cmd_len2), .cmd_data_i(cmd_data2),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_data_o(rsp_data2),
    .jtag_tck_o(tck2), .jtag_tms_o(tms2), .jtag_tdi_o(tdi2), .jtag_tdo_i(tdo2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb_q[$];

  // ---------------- behavioural target TAP ----------------
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_e;
  tap_e        tap_st   = TLR;
  logic [4:0]  tap_ir   = 5'h01;
  logic [4:0]  tap_irsr = 5'h00;
  logic [63:0] tap_drsr = 64'h0;
  logic [63:0] tap_user = USER_INIT;
  logic        tap_tdo  = 1'b0;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PADR;
      PADR:    return m ? EX2DR : PADR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAIR;
      PAIR:    return m ? EX2IR : PAIR;
      EX2IR:   return m ? UPIR  : SHIR;
      UPIR:    return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge tck1) begin
    case (tap_st)
      TLR:   tap_ir <= 5'h01;
      CAPDR: tap_drsr <= (tap_ir == 5'h01) ? {32'h0, IDCODE} :
                         (tap_ir == 5'h04) ? tap_user : 64'h0;
      SHDR:  tap_drsr <= {tdi1, tap_drsr[63:1]};
      UPDR:  if (tap_ir == 5'h04) tap_user <= tap_drsr;
      CAPIR: tap_irsr <= 5'b00001;
      SHIR:  tap_irsr <= {tdi1, tap_irsr[4:1]};
      UPIR:  tap_ir <= tap_irsr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms1);
  end

  always @(negedge tck1) begin
    tap_tdo <= (tap_st == SHDR) ? tap_drsr[0] : (tap_st == SHIR) ? tap_irsr[0] : 1'b0;
  end
  assign tdo1 = tap_tdo;

  // ---------------- TCK-rise logs ----------------
  logic tms_hist[$];
  logic tdi_hist[$];
  logic tms2_hist[$];
  int   r2cnt = 0;
  int   base2 = 0;
  logic [7:0] pat2 = 8'h00;

  always @(posedge tck1) begin
    tms_hist.push_back(tms1);
    tdi_hist.push_back(tdi1);
  end

  always @(posedge tck2) begin
    tms2_hist.push_back(tms2);
    r2cnt++;
  end
  // TDO presented before rise k (k from 0) of the current fast-instance command.
  assign tdo2 = pat2[3'(r2cnt - base2)];

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected TCK count and per-rise TMS/TDI for a command, from Run-Test/Idle.
  function automatic void build_exp(input logic rst, input logic ir, input int L,
                                    input logic [63:0] d, output int n,
                                    output logic [127:0] etms, output logic [127:0] etdi);
    int s;
    etms = '0;
    etdi = '0;
    if (rst) begin
      n = 6;
      etms[4:0] = 5'b11111;
    end else begin
      s = ir ? 4 : 3;
      n = L + s + 2;
      etms[0] = 1'b1;
      if (ir) etms[1] = 1'b1;
      for (int i = 0; i < L; i++) etdi[s + i] = d[i];
      etms[s + L - 1] = 1'b1;
      etms[s + L]     = 1'b1;
    end
  endfunction

  task automatic run_cmd(input string tag, input logic rst, input logic ir, input int L,
                         input logic [63:0] d, input logic [63:0] exp_rsp, input int hold);
    int n, base, c, nobs;
    logic [127:0] etms, etdi, otms, otdi;
    logic [63:0] e;
    bit ok;
    build_exp(rst, ir, L, d, n, etms, etdi);
    sb_q.push_back(exp_rsp);
    base = tms_hist.size();
    cmd_reset = rst; cmd_ir = ir; cmd_len = 6'(L - 1); cmd_data = d; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      tick();
    end
    chk({tag, " accept"}, 128'(ok), 128'(1));
    if (!ok) begin
      cmd_valid = 1'b0;
      void'(sb_q.pop_back());
      return;
    end
    tick();
    cmd_valid = 1'b0;
    chk({tag, " ready_drop"}, 128'(cmd_ready), 128'(0));
    c = 0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      c++;
      if (rsp_valid) break;
    end
    chk({tag, " latency"}, 128'(c), 128'(n * 8));
    chk({tag, " ready_in_resp"}, 128'(cmd_ready), 128'(0));
    if (hold > 0) begin
      cmd_valid = 1'b1;
      cmd_data  = ~d;
      for (int h = 0; h < hold; h++) begin
        tick();
        chk({tag, " hold_valid"}, 128'(rsp_valid), 128'(1));
        chk({tag, " hold_data"}, 128'(rsp_data), 128'(sb_q[0]));
        chk({tag, " hold_ready"}, 128'(cmd_ready), 128'(0));
        chk({tag, " hold_tck"}, 128'(tck1), 128'(0));
      end
      cmd_valid = 1'b0;
    end
    e = sb_q.pop_front();
    chk({tag, " rsp_data"}, 128'(rsp_data), 128'(e));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, " valid_drop"}, 128'(rsp_valid), 128'(0));
    chk({tag, " ready_back"}, 128'(cmd_ready), 128'(1));
    nobs = tms_hist.size() - base;
    otms = '0;
    otdi = '0;
    for (int i = 0; i < nobs && i < 128; i++) begin
      otms[i] = tms_hist[base + i];
      otdi[i] = tdi_hist[base + i];
    end
    chk({tag, " tck_count"}, 128'(nobs), 128'(n));
    chk({tag, " tms_seq"}, otms, etms);
    chk({tag, " tdi_seq"}, otdi, etdi);
    chk({tag, " tap_rti"}, 128'(tap_st), 128'(RTI));
  endtask

  // Releases reset and checks the start-up walk of the CLK_DIV=4 instance.
  task automatic init_seq(input string tag);
    int base, c, nobs;
    bit seen_valid;
    logic [127:0] otms, otdi;
    base = tms_hist.size();
    rst_n = 1'b1;
    tick();
    chk({tag, " ready_first_edge"}, 128'(cmd_ready), 128'(0));
    c = 0;
    seen_valid = 1'b0;
    for (int k = 0; k < 500; k++) begin
      tick();
      c++;
      if (rsp_valid) seen_valid = 1'b1;
      if (cmd_ready) break;
    end
    chk({tag, " ready_delay"}, 128'(c), 128'(48));
    chk({tag, " no_response"}, 128'(seen_valid), 128'(0));
    nobs = tms_hist.size() - base;
    otms = '0;
    otdi = '0;
    for (int i = 0; i < nobs && i < 128; i++) begin
      otms[i] = tms_hist[base + i];
      otdi[i] = tdi_hist[base + i];
    end
    chk({tag, " tck_count"}, 128'(nobs), 128'(6));
    chk({tag, " tms_seq"}, otms, 128'(6'b011111));
    chk({tag, " tdi_zero"}, otdi, 128'(0));
    chk({tag, " tap_rti"}, 128'(tap_st), 128'(RTI));
  endtask

  task automatic run_cmd2(input string tag, input logic [7:0] pat, input logic [63:0] d,
                          input logic [63:0] exp_rsp);
    int n, base, c, nt, nobs;
    logic [127:0] etms, etdi, otms;
    logic prev;
    bit ok;
    build_exp(1'b0, 1'b0, 1, d, n, etms, etdi);
    pat2  = pat;
    base2 = r2cnt;
    base  = tms2_hist.size();
    cmd_reset2 = 1'b0; cmd_ir2 = 1'b0; cmd_len2 = 6'd0; cmd_data2 = d; cmd_valid2 = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (cmd_ready2) begin ok = 1'b1; break; end
      tick();
    end
    chk({tag, " accept"}, 128'(ok), 128'(1));
    tick();
    cmd_valid2 = 1'b0;
    prev = tck2;
    c = 0;
    nt = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      c++;
      if (tck2 === prev) nt++;
      prev = tck2;
      if (rsp_valid2) break;
    end
    chk({tag, " latency"}, 128'(c), 128'(n * 2));
    chk({tag, " tck_nontoggle"}, 128'(nt), 128'(0));
    chk({tag, " rsp_data"}, 128'(rsp_data2), 128'(exp_rsp));
    rsp_ready2 = 1'b1;
    tick();
    rsp_ready2 = 1'b0;
    chk({tag, " valid_drop"}, 128'(rsp_valid2), 128'(0));
    nobs = tms2_hist.size() - base;
    otms = '0;
    for (int i = 0; i < nobs && i < 128; i++) otms[i] = tms2_hist[base + i];
    chk({tag, " tck_count"}, 128'(nobs), 128'(n));
    chk({tag, " tms_seq"}, otms, etms);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    cmd_valid = 1'b0; cmd_reset = 1'b0; cmd_ir = 1'b0; cmd_len = '0; cmd_data = '0;
    rsp_ready = 1'b0;
    cmd_valid2 = 1'b0; cmd_reset2 = 1'b0; cmd_ir2 = 1'b0; cmd_len2 = '0; cmd_data2 = '0;
    rsp_ready2 = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();

    chk("rst tck", 128'(tck1), 128'(0));
    chk("rst tms", 128'(tms1), 128'(1));
    chk("rst tdi", 128'(tdi1), 128'(0));
    chk("rst ready", 128'(cmd_ready), 128'(0));
    chk("rst valid", 128'(rsp_valid), 128'(0));
    chk("rst rsp_data", 128'(rsp_data), 128'(0));
    chk("rst fast tms", 128'(tms2), 128'(1));

    init_seq("init");

    run_cmd("ir_idcode",   1'b0, 1'b1, 5,  64'h01, 64'h01, 0);
    run_cmd("dr_idcode",   1'b0, 1'b0, 32, 64'h0,  {32'h0, IDCODE}, 0);
    run_cmd("ir_user",     1'b0, 1'b1, 5,  64'h04, 64'h01, 0);
    run_cmd("dr_user64",   1'b0, 1'b0, 64, PAT_A5, USER_INIT, 20);
    chk("user_reg_written", 128'(tap_user), 128'(PAT_A5));
    run_cmd("dr_user_rb",  1'b0, 1'b0, 64, 64'h0,  PAT_A5, 0);
    run_cmd("tap_reset",   1'b1, 1'b0, 5,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0);
    run_cmd("dr_after_rst",1'b0, 1'b0, 32, 64'h0,  {32'h0, IDCODE}, 0);
    run_cmd("dr_len1",     1'b0, 1'b0, 1,  64'h1,  64'h1, 0);
    run_cmd("ir_user2",    1'b0, 1'b1, 5,  64'h04, 64'h01, 0);

    // Reset asserted in the middle of a DR scan.
    cmd_reset = 1'b0; cmd_ir = 1'b0; cmd_len = 6'd31; cmd_data = 64'hFFFF_FFFF; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      tick();
    end
    chk("midrst accept", 128'(ok), 128'(1));
    tick();
    cmd_valid = 1'b0;
    repeat (148) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst tck", 128'(tck1), 128'(0));
    chk("midrst tms", 128'(tms1), 128'(1));
    chk("midrst tdi", 128'(tdi1), 128'(0));
    chk("midrst ready", 128'(cmd_ready), 128'(0));
    chk("midrst valid", 128'(rsp_valid), 128'(0));
    chk("midrst rsp_data", 128'(rsp_data), 128'(0));
    repeat (3) tick();
    init_seq("reinit");
    chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));
    run_cmd("dr_post_reinit", 1'b0, 1'b0, 32, 64'h0, {32'h0, IDCODE}, 0);

    run_cmd2("fast_l1_one",  8'h08, 64'h1, 64'h1);
    run_cmd2("fast_l1_zero", 8'hF7, 64'h0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_host_master.md
# jtag_host_master

Host-side JTAG initiator that drives a target TAP (the SoC debug TAP on pad_jtag_tck/tms/tdi/tdo) from inside the FPGA fabric, for on-board self-test and a debug bridge without an external probe. A simple command/response handshake requests an IR scan, a DR scan or a TAP reset. The block generates TCK, TMS and TDI, and returns the captured TDO bits. It sits beside the pulpissimo instance, clocked by the reference clock.

## Interface
Parameters:
- CLK_DIV, 4: clk_i cycles per TCK half-period; legal range ≥1.
- MAX_LEN, 64: maximum scan length in bits; legal range ≥2.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_ni  in  1  reset; asynchronous, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accept.
- cmd_reset_i  in  1  1 = TAP reset command; cmd_ir_i, cmd_len_i and cmd_data_i are ignored.
- cmd_ir_i  in  1  1 = IR scan, 0 = DR scan.
- cmd_len_i  in  $clog2(MAX_LEN)  scan length minus one (L = cmd_len_i+1).
- cmd_data_i  in  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response accept.
- rsp_data_o  out  MAX_LEN  captured TDO bits; bit i = TDO of shift i; bits ≥L are 0.
- jtag_tck_o  out  1  TCK.
- jtag_tms_o  out  1  TMS.
- jtag_tdi_o  out  1  TDI.
- jtag_tdo_i  in  1  TDO from target.

## Operation
- Reset values: jtag_tck_o=0, jtag_tms_o=1, jtag_tdi_o=0, cmd_ready_o=0, rsp_valid_o=0, rsp_data_o=0.
- FSM states: INIT, IDLE, SCAN, RESP.
- INIT: entered on reset release. Issues 5 TCK with TMS=1, then 1 TCK with TMS=0, leaving the TAP in Run-Test/Idle. Goes to IDLE; no response is produced.
- IDLE: cmd_ready_o=1, TCK held at 0. A command is accepted when cmd_valid_i and cmd_ready_o are both 1 on a clock edge. Inputs are latched on that edge and the FSM goes to SCAN.
- SCAN TMS sequence, starting from Run-Test/Idle:
  - DR scan: 1,0,0, then L shift bits (TMS=0 except the last, which is 1), then 1,0. Total L+5 TCK.
  - IR scan: 1,1,0,0, then L shift bits (last TMS=1), then 1,0. Total L+6 TCK.
  - Reset command: 1,1,1,1,1,0. Total 6 TCK; response data is 0.
- TDI equals cmd_data bit i during shift bit i. During non-shift bits TDI is 0.
- TDO is sampled only during shift bits. rsp_data bit i is stored on the edge where TCK rises in shift bit i.
- RESP: rsp_valid_o=1 and rsp_data_o is stable until rsp_valid_o and rsp_ready_i are both 1 on an edge. Then the FSM returns to IDLE. cmd_ready_o=0 in INIT, SCAN and RESP.
- Every command ends in Run-Test/Idle.
- Asynchronous reset mid-scan: the in-flight command is dropped with no response, outputs take their reset values, and INIT reruns after release.

## Timing
- One TCK period is 2·CLK_DIV clk cycles: a low half followed by a high half.
- TMS and TDI update on the edge that starts the low half (TCK falling edge or idle). They are stable for the whole period.
- TDO is sampled on the clk edge that drives jtag_tck_o 0→1.
- The first low half starts on the edge after the accept edge.
- rsp_valid_o rises on the edge that ends the last high half; TCK returns to 0 on that same edge. This is N·2·CLK_DIV cycles after the accept edge, where N is the TCK count above.
- The next command can be accepted at the earliest on the edge after the response handshake.
- INIT: cmd_ready_o rises 12·CLK_DIV cycles after the first edge following reset release.
- CLK_DIV=1: TCK toggles every clk cycle; all rules above still apply.

## Test plan
- Reset release, CLK_DIV=4 → exactly 6 TCK pulses with TMS 1,1,1,1,1,0; cmd_ready_o rises 48 cycles after release; TDI stays 0.
- Target is a behavioural TAP model (IR 5 bits, IDCODE 0x249511C3). IR scan L=5, data 0x01, then DR scan L=32 → rsp_data_o=0x249511C3. DR rsp_valid_o arrives 37·8 cycles after accept.
- DR scan L=MAX_LEN=64 into a 64-bit model register preloaded with 0xDEADBEEF_01234567, with data 0xA5A5... → rsp_data_o=0xDEADBEEF_01234567; the model register then holds the TDI pattern.
- Hold rsp_ready_i low for 20 cycles → rsp_valid_o and rsp_data_o stay constant, cmd_ready_o stays 0, TCK stays 0. A cmd_valid_i asserted during this time is not accepted.
- Assert rst_ni low halfway through a DR scan → all outputs take reset values immediately, no response is produced, and INIT reruns after release.
- CLK_DIV=1, L=1 DR scan → 6 TCK pulses, TCK toggles every cycle, TMS sequence 1,0,0,1,1,0, rsp bit0 = TDO sampled on the 4th TCK rise.
